// File: rtl/mem_port_arbiter_if.sv
// Shared memory-port bundle: fetch side, data side and the SRAM-like memory side.
interface mem_port_arbiter_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        inst_data_ok;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_data_ok;
   logic        mem_req;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;

   modport slave (
      input  inst_req, inst_addr,
      output inst_rdata, inst_data_ok,
      input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
      output data_rdata, data_data_ok,
      output mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
      input  mem_addr_ok, mem_data_ok, mem_rdata
   );

   modport master (
      output inst_req, inst_addr,
      input  inst_rdata, inst_data_ok,
      output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
      input  data_rdata, data_data_ok,
      input  mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
      output mem_addr_ok, mem_data_ok, mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data access.
// Data wins ties unless fetch has been passed over STARVE_LIMIT times.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   mem_port_arbiter_if.slave bus,
   output logic             stallreq_inst,
   output logic             stallreq_data
);
   typedef enum logic [2:0] {
      IDLE,
      I_ADDR,
      I_DATA,
      D_ADDR,
      D_DATA
   } state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t     state;
   logic [3:0] starve_cnt;
   logic       discard;

   logic inst_elig;
   logic data_elig;
   logic starved;
   logic grant_d;
   logic grant_i;

   // A requester whose ok pulse is out this cycle still shows req high; skip it.
   always_comb begin
      inst_elig = bus.inst_req & ~bus.inst_data_ok;
      data_elig = bus.data_req & ~bus.data_data_ok;
      starved   = (starve_cnt == LIMIT);
      grant_d   = (state == IDLE) & data_elig & (~inst_elig | ~starved);
      grant_i   = (state == IDLE) & inst_elig & ~grant_d;
   end

   assign stallreq_inst = bus.inst_req & ~bus.inst_data_ok;
   assign stallreq_data = bus.data_req & ~bus.data_data_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         starve_cnt       <= 4'd0;
         discard          <= 1'b0;
         bus.mem_req      <= 1'b0;
         bus.mem_wr       <= 1'b0;
         bus.mem_size     <= 2'd0;
         bus.mem_addr     <= 32'd0;
         bus.mem_wstrb    <= 4'd0;
         bus.mem_wdata    <= 32'd0;
         bus.inst_rdata   <= 32'd0;
         bus.inst_data_ok <= 1'b0;
         bus.data_rdata   <= 32'd0;
         bus.data_data_ok <= 1'b0;
      end else begin
         bus.inst_data_ok <= 1'b0;
         bus.data_data_ok <= 1'b0;
         unique case (state)
            IDLE: begin
               if (grant_d) begin
                  state         <= D_ADDR;
                  bus.mem_req   <= 1'b1;
                  bus.mem_wr    <= bus.data_wr;
                  bus.mem_size  <= bus.data_size;
                  bus.mem_addr  <= bus.data_addr;
                  bus.mem_wstrb <= bus.data_wstrb;
                  bus.mem_wdata <= bus.data_wdata;
                  // grant_d with fetch eligible implies not yet saturated
                  if (inst_elig) starve_cnt <= starve_cnt + 4'd1;
               end else if (grant_i) begin
                  state         <= I_ADDR;
                  bus.mem_req   <= 1'b1;
                  bus.mem_wr    <= 1'b0;
                  bus.mem_size  <= 2'd2;
                  bus.mem_addr  <= bus.inst_addr;
                  bus.mem_wstrb <= 4'd0;
                  bus.mem_wdata <= 32'd0;
                  starve_cnt    <= 4'd0;
                  discard       <= flush;
               end
            end
            I_ADDR: begin
               if (flush) discard <= 1'b1;
               if (bus.mem_addr_ok) begin
                  state       <= I_DATA;
                  bus.mem_req <= 1'b0;
               end
            end
            D_ADDR: begin
               if (bus.mem_addr_ok) begin
                  state       <= D_DATA;
                  bus.mem_req <= 1'b0;
               end
            end
            I_DATA: begin
               if (flush) discard <= 1'b1;
               if (bus.mem_data_ok) begin
                  state   <= IDLE;
                  discard <= 1'b0;
                  if (!discard && !flush) begin
                     bus.inst_rdata   <= bus.mem_rdata;
                     bus.inst_data_ok <= 1'b1;
                  end
               end
            end
            D_DATA: begin
               if (bus.mem_data_ok) begin
                  state            <= IDLE;
                  bus.data_rdata   <= bus.mem_rdata;
                  bus.data_data_ok <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;
   localparam int LIMIT = 4;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } dreq_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   logic stallreq_inst;
   logic stallreq_data;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .bus(bus),
      .stallreq_inst(stallreq_inst),
      .stallreq_data(stallreq_data)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [31:0] iq[$];
   dreq_t       dq[$];
   bit          inst_gap = 1'b0;
   int          addr_dly = 1;
   int          data_dly = 1;

   // model state: one transaction record
   bit    m_ok = 1'b0;
   bit    m_busy = 1'b0;
   bit    m_acc = 1'b0;
   bit    m_kill = 1'b0;
   int    m_who = 0;
   dreq_t m_t;
   int    m_starve = 0;
   bit    e_iok = 1'b0;
   bit    e_dok = 1'b0;
   logic [31:0] e_ird = '0;
   logic [31:0] e_drd = '0;
   string m_log = "";

   // observations of the DUT
   string dlog = "";
   logic [31:0] g_addr[$];
   logic        g_wr[$];
   int          runs[$];
   int          i_cyc[$];
   logic [31:0] i_data[$];
   int          d_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_s(input string nm, input string act, input string exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
      end
   endtask

   task automatic drive();
      bus.inst_req  = (iq.size() > 0) && !(inst_gap && bus.data_data_ok);
      bus.inst_addr = (iq.size() > 0) ? iq[0] : 32'h0;
      if (dq.size() > 0) begin
         bus.data_req = 1'b1;
         {bus.data_wr, bus.data_size, bus.data_addr,
          bus.data_wstrb, bus.data_wdata} = dq[0];
      end else begin
         bus.data_req = 1'b0;
         {bus.data_wr, bus.data_size, bus.data_addr,
          bus.data_wstrb, bus.data_wdata} = '0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [31:0] mem_image(input logic [31:0] a);
      return (a == 32'hBFC00000) ? 32'h3C1D0000 : ~a;
   endfunction

   initial begin
      bus.inst_req = 1'b0;
      bus.inst_addr = '0;
      bus.data_req = 1'b0;
      bus.data_wr = 1'b0;
      bus.data_size = '0;
      bus.data_addr = '0;
      bus.data_wstrb = '0;
      bus.data_wdata = '0;
      bus.mem_addr_ok = 1'b0;
      bus.mem_data_ok = 1'b0;
      bus.mem_rdata = '0;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // requesters: pop on the ok pulse, otherwise hold
   initial forever begin
      bit iok, dok, r;
      @(posedge clk);
      iok = bus.inst_data_ok;
      dok = bus.data_data_ok;
      r = rst;
      #1;
      if (r) begin
         iq.delete();
         dq.delete();
      end else begin
         if (iok && iq.size() > 0) void'(iq.pop_front());
         if (dok && dq.size() > 0) void'(dq.pop_front());
      end
      drive();
   end

   // memory responder with programmable address and data latency
   initial begin
      int acnt, dcnt;
      logic [31:0] rsp;
      acnt = 0;
      dcnt = 0;
      rsp = '0;
      forever begin
         @(posedge clk);
         if (rst) begin
            acnt = 0;
            dcnt = 0;
         end else if (bus.mem_req && bus.mem_addr_ok) begin
            dcnt = data_dly;
            rsp = mem_image(bus.mem_addr);
            acnt = 0;
         end
         #1;
         bus.mem_addr_ok = 1'b0;
         bus.mem_data_ok = 1'b0;
         if (bus.mem_req && !rst) begin
            acnt++;
            bus.mem_addr_ok = (acnt >= addr_dly);
         end
         if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) begin
               bus.mem_data_ok = 1'b1;
               bus.mem_rdata = rsp;
            end
         end
      end
   end

   // reference model, advanced on each rising edge from the sampled inputs
   initial forever begin
      bit niok, ndok, ie, de;
      @(posedge clk);
      niok = 1'b0;
      ndok = 1'b0;
      if (rst) begin
         m_ok = 1'b1;
         m_busy = 1'b0;
         m_acc = 1'b0;
         m_kill = 1'b0;
         m_starve = 0;
         e_ird = '0;
         e_drd = '0;
      end else if (m_busy) begin
         if (flush && m_who == 1) m_kill = 1'b1;
         if (!m_acc) begin
            m_acc = bus.mem_addr_ok;
         end else if (bus.mem_data_ok) begin
            if (m_who == 2) begin
               ndok = 1'b1;
               e_drd = bus.mem_rdata;
            end else if (!m_kill) begin
               niok = 1'b1;
               e_ird = bus.mem_rdata;
            end
            m_busy = 1'b0;
            m_kill = 1'b0;
         end
      end else begin
         ie = bus.inst_req && !e_iok;
         de = bus.data_req && !e_dok;
         if (de && (!ie || m_starve != LIMIT)) begin
            m_busy = 1'b1;
            m_acc = 1'b0;
            m_who = 2;
            m_t = {bus.data_wr, bus.data_size, bus.data_addr,
                   bus.data_wstrb, bus.data_wdata};
            if (ie && m_starve < LIMIT) m_starve++;
            m_log = {m_log, "D"};
         end else if (ie) begin
            m_busy = 1'b1;
            m_acc = 1'b0;
            m_who = 1;
            m_t = {1'b0, 2'd2, bus.inst_addr, 4'h0, 32'h0};
            m_starve = 0;
            m_kill = flush;
            m_log = {m_log, "I"};
         end
      end
      e_iok = niok;
      e_dok = ndok;
   end

   // per-cycle comparison against the model, plus event capture
   initial begin
      bit prev_req;
      bit e_req;
      int run;
      prev_req = 1'b0;
      run = 0;
      forever begin
         @(negedge clk);
         if (m_ok) begin
            e_req = m_busy && !m_acc;
            chk("mem_req", 32'(bus.mem_req), 32'(e_req));
            if (e_req) begin
               chk("mem_wr", 32'(bus.mem_wr), 32'(m_t.wr));
               chk("mem_size", 32'(bus.mem_size), 32'(m_t.size));
               chk("mem_addr", bus.mem_addr, m_t.addr);
               chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(m_t.wstrb));
               chk("mem_wdata", bus.mem_wdata, m_t.wdata);
            end
            chk("inst_data_ok", 32'(bus.inst_data_ok), 32'(e_iok));
            chk("data_data_ok", 32'(bus.data_data_ok), 32'(e_dok));
            if (e_iok) chk("inst_rdata", bus.inst_rdata, e_ird);
            if (e_dok) chk("data_rdata", bus.data_rdata, e_drd);
            chk("stallreq_inst", 32'(stallreq_inst),
                32'(bus.inst_req && !e_iok));
            chk("stallreq_data", 32'(stallreq_data),
                32'(bus.data_req && !e_dok));
         end
         if (bus.mem_req === 1'b1 && !prev_req) begin
            if (bus.mem_addr[31:28] == 4'hB) dlog = {dlog, "I"};
            else dlog = {dlog, "D"};
            g_addr.push_back(bus.mem_addr);
            g_wr.push_back(bus.mem_wr);
         end
         if (bus.mem_req === 1'b1) begin
            run++;
         end else if (run > 0) begin
            runs.push_back(run);
            run = 0;
         end
         prev_req = (bus.mem_req === 1'b1);
         if (bus.inst_data_ok === 1'b1) begin
            i_cyc.push_back(cyc);
            i_data.push_back(bus.inst_rdata);
         end
         if (bus.data_data_ok === 1'b1) d_cnt++;
      end
   end

   task automatic clear_logs();
      dlog = "";
      m_log = "";
      g_addr.delete();
      g_wr.delete();
      runs.delete();
      i_cyc.delete();
      i_data.delete();
      d_cnt = 0;
   endtask

   task automatic wait_done(input string nm, input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         tick();
         done = (iq.size() == 0) && (dq.size() == 0) && !m_busy;
      end
      vectors++;
      if (!done) begin
         miscompares++;
         $display("FAIL %s timeout: still busy after %0d cycles, required idle",
                  nm, budget);
      end
      tick();
   endtask

   task automatic wait_accepted(input string nm, input int who);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 50 && !hit; i++) begin
         tick();
         hit = m_busy && m_acc && (m_who == who);
      end
      vectors++;
      if (!hit) begin
         miscompares++;
         $display("FAIL %s timeout: address phase not reached, required within 50 cycles",
                  nm);
      end
   endtask

   initial begin
      int c0;
      repeat (2) tick();
      chk("reset mem_req", 32'(bus.mem_req), 32'h0);
      chk("reset mem_wr", 32'(bus.mem_wr), 32'h0);
      chk("reset mem_addr", bus.mem_addr, 32'h0);
      chk("reset mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
      chk("reset inst_rdata", bus.inst_rdata, 32'h0);
      chk("reset data_rdata", bus.data_rdata, 32'h0);
      chk("reset inst_data_ok", 32'(bus.inst_data_ok), 32'h0);
      chk("reset data_data_ok", 32'(bus.data_data_ok), 32'h0);
      rst = 1'b0;
      tick();

      // fetch only, minimum latency
      clear_logs();
      iq.push_back(32'hBFC00000);
      drive();
      c0 = cyc;
      wait_done("t1", 20);
      chk_s("t1 grants", dlog, "I");
      chk("t1 mem_addr", g_addr.size() > 0 ? g_addr[0] : 32'hX, 32'hBFC00000);
      chk("t1 mem_wr", g_wr.size() > 0 ? 32'(g_wr[0]) : 32'hX, 32'h0);
      chk("t1 ok count", 32'(i_cyc.size()), 32'd1);
      chk("t1 latency", i_cyc.size() > 0 ? 32'(i_cyc[0] - c0) : 32'hX, 32'd3);
      chk("t1 rdata", i_data.size() > 0 ? i_data[0] : 32'hX, 32'h3C1D0000);

      // simultaneous store and fetch
      clear_logs();
      iq.push_back(32'hBFC00004);
      dq.push_back({1'b1, 2'd2, 32'h80001000, 4'hF, 32'h12345678});
      drive();
      wait_done("t2", 30);
      chk_s("t2 grants", dlog, "DI");
      chk_s("t2 model grants", m_log, "DI");
      chk("t2 store wr", g_wr.size() > 0 ? 32'(g_wr[0]) : 32'hX, 32'h1);
      chk("t2 store addr", g_addr.size() > 0 ? g_addr[0] : 32'hX, 32'h80001000);
      chk("t2 inst ok", 32'(i_cyc.size()), 32'd1);
      chk("t2 data ok", 32'(d_cnt), 32'd1);

      // starvation: fetch momentarily withdrawn on each data ok pulse
      clear_logs();
      inst_gap = 1'b1;
      iq.push_back(32'hBFC00008);
      for (int k = 0; k < 5; k++)
         dq.push_back({1'b0, 2'd2, 32'h80002000 + 32'(4 * k), 4'h0, 32'h0});
      drive();
      wait_done("t3", 80);
      inst_gap = 1'b0;
      chk_s("t3 grants", dlog, "DDDDID");
      chk_s("t3 model grants", m_log, "DDDDID");
      chk("t3 data ok", 32'(d_cnt), 32'd5);
      chk("t3 inst ok", 32'(i_cyc.size()), 32'd1);

      // flush during fetch data phase kills the response
      clear_logs();
      data_dly = 3;
      iq.push_back(32'hBFC00100);
      drive();
      wait_accepted("t4", 1);
      flush = 1'b1;
      iq[0] = 32'hBFC00380;
      drive();
      tick();
      flush = 1'b0;
      data_dly = 1;
      wait_done("t4", 30);
      chk_s("t4 grants", dlog, "II");
      chk("t4 new pc", g_addr.size() > 1 ? g_addr[1] : 32'hX, 32'hBFC00380);
      chk("t4 inst ok", 32'(i_cyc.size()), 32'd1);
      chk("t4 rdata", i_data.size() > 0 ? i_data[0] : 32'hX, 32'h403FFC7F);

      // slow address acceptance
      clear_logs();
      addr_dly = 4;
      dq.push_back({1'b1, 2'd0, 32'h80003003, 4'h8, 32'hAB000000});
      drive();
      wait_done("t5", 30);
      addr_dly = 1;
      chk("t5 req cycles", runs.size() > 0 ? 32'(runs[0]) : 32'hX, 32'd4);
      chk("t5 data ok", 32'(d_cnt), 32'd1);

      // reset during data phase
      clear_logs();
      data_dly = 6;
      dq.push_back({1'b0, 2'd1, 32'h80004002, 4'h0, 32'h0});
      drive();
      wait_accepted("t6", 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      data_dly = 1;
      chk("t6 mem_req", 32'(bus.mem_req), 32'h0);
      chk("t6 data ok", 32'(bus.data_data_ok), 32'h0);
      chk("t6 inst ok", 32'(bus.inst_data_ok), 32'h0);
      repeat (8) tick();
      chk("t6 no late ok", 32'(d_cnt), 32'd0);
      iq.push_back(32'hBFC00200);
      drive();
      wait_done("t6", 20);
      chk("t6 fetch after reset", 32'(i_cyc.size()), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
